// File: rtl/mod_id_pipe.sv
// Decode stage: register file, opcode decode, branch resolution, load-use stall and ID/EX register.
// Optional macro WB_BYPASS_EN forwards a same-cycle write-back to the register reads.
module mod_id_pipe #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [2:0]        flags,
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              halted,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [11:0]       out_ctrl,
  output logic [DATA_W-1:0] out_src1,
  output logic [DATA_W-1:0] out_src2,
  output logic [IMM_W-1:0]  out_imm,
  output logic [REG_AW-1:0] out_dst
);
  localparam int NREG = 2 ** REG_AW;

  localparam logic [3:0] OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_LW = 4'h8,
                         OP_SW = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB, OP_B = 4'hC,
                         OP_BR = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF;

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];
  logic              halted_q, halted_d;
  logic              out_valid_q, out_valid_d;
  logic [11:0]       ctrl_q, ctrl_d;
  logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic [REG_AW-1:0] dst_q, dst_d;

  logic [3:0]        opcode;
  logic [REG_AW-1:0] rd_idx, rs_idx, rt_idx, src1_idx, src2_idx;
  logic              src1_used, src2_used, is_b, is_br, cond_true;
  logic              z_f, v_f, n_f;
  logic              stall, accept;
  logic [DATA_W-1:0] src1_rd, src2_rd, src1_data, b_off;
  logic [IMM_W-1:0]  imm;
  logic [11:0]       ctrl;
  logic              c_regwrite, c_alusrc, c_memen, c_memwrite, c_memtoreg, c_pcread;
  logic [1:0]        c_branch;

  assign opcode = in_instr[15:12];
  assign rd_idx = in_instr[8 +: REG_AW];
  assign rs_idx = in_instr[4 +: REG_AW];
  assign rt_idx = in_instr[0 +: REG_AW];
  assign {z_f, v_f, n_f} = flags;

  always_comb begin
    src1_idx = (opcode == OP_LLB || opcode == OP_LHB) ? rd_idx : rs_idx;
    src2_idx = (opcode == OP_SW) ? rd_idx : rt_idx;
    src1_rd  = rf_q[src1_idx];
    src2_rd  = rf_q[src2_idx];
`ifdef WB_BYPASS_EN
    if (wb_we && wb_dst == src1_idx) src1_rd = wb_data;
    if (wb_we && wb_dst == src2_idx) src2_rd = wb_data;
`endif
    if (src1_idx == '0) src1_rd = '0;
    if (src2_idx == '0) src2_rd = '0;
    src1_data = (opcode == OP_PCS) ? in_pc : src1_rd;
  end

  // ctrl = {regwrite,alusrc,memen,memwrite,memtoreg,pcread,aluop=opcode,branch={BR,B}}
  always_comb begin
    c_regwrite = 1'b0; c_alusrc = 1'b0; c_memen = 1'b0; c_memwrite = 1'b0;
    c_memtoreg = 1'b0; c_pcread = 1'b0; c_branch = 2'b00;
    src1_used  = 1'b0; src2_used = 1'b0;
    imm        = '0;
    case (opcode)
      OP_SLL, OP_SRA, OP_ROR: begin
        c_regwrite = 1'b1; c_alusrc = 1'b1; src1_used = 1'b1;
        imm = {{(IMM_W-4){1'b0}}, in_instr[3:0]};
      end
      OP_LW, OP_SW: begin
        c_alusrc = 1'b1; c_memen = 1'b1; src1_used = 1'b1;
        c_regwrite = (opcode == OP_LW); c_memtoreg = (opcode == OP_LW);
        c_memwrite = (opcode == OP_SW); src2_used = (opcode == OP_SW);
        imm = {{(IMM_W-5){in_instr[3]}}, in_instr[3:0], 1'b0};
      end
      OP_LLB, OP_LHB: begin
        c_regwrite = 1'b1; c_alusrc = 1'b1; src1_used = 1'b1;
        imm = {{(IMM_W-8){1'b0}}, in_instr[7:0]};
      end
      OP_B: begin
        c_branch = 2'b01;
        imm = {{(IMM_W-10){in_instr[8]}}, in_instr[8:0], 1'b0};
      end
      OP_BR: begin
        c_branch = 2'b10; src1_used = 1'b1;
      end
      OP_PCS: begin
        c_regwrite = 1'b1; c_pcread = 1'b1;
      end
      OP_HLT: ;
      default: begin
        c_regwrite = 1'b1; src1_used = 1'b1; src2_used = 1'b1;
        imm = {{(IMM_W-4){in_instr[3]}}, in_instr[3:0]};
      end
    endcase
    ctrl = {c_regwrite, c_alusrc, c_memen, c_memwrite, c_memtoreg, c_pcread, opcode, c_branch};
  end

  always_comb begin
    case (in_instr[11:9])
      3'd0:    cond_true = ~z_f;
      3'd1:    cond_true = z_f;
      3'd2:    cond_true = ~z_f & ~n_f;
      3'd3:    cond_true = n_f;
      3'd4:    cond_true = z_f | ~n_f;
      3'd5:    cond_true = z_f | n_f;
      3'd6:    cond_true = v_f;
      default: cond_true = 1'b1;
    endcase
  end

  assign is_b   = (opcode == OP_B);
  assign is_br  = (opcode == OP_BR);
  assign b_off  = {{(DATA_W-10){in_instr[8]}}, in_instr[8:0], 1'b0};
  assign stall  = in_valid & ex_valid & ex_memread & (ex_dst != '0) &
                  ((src1_used & (ex_dst == src1_idx)) | (src2_used & (ex_dst == src2_idx)));
  assign in_ready    = ~halted_q & ~stall & (~out_valid_q | out_ready);
  assign accept      = in_valid & in_ready;
  assign redirect    = accept & (is_b | is_br) & cond_true;
  assign redirect_pc = is_br ? src1_rd : in_pc + b_off;

  always_comb begin
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    imm_d       = imm_q;
    dst_d       = dst_q;
    halted_d    = halted_q | (accept & (opcode == OP_HLT));
    if (accept) begin
      out_valid_d = 1'b1;
      ctrl_d      = ctrl;
      src1_d      = src1_data;
      src2_d      = src2_rd;
      imm_d       = imm;
      dst_d       = rd_idx;
    end else if (~out_valid_q | out_ready) begin
      out_valid_d = 1'b0;
    end
    rf_d = rf_q;
    if (wb_we && wb_dst != '0) rf_d[wb_dst] = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_q        <= '{default: '0};
      halted_q    <= 1'b0;
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      imm_q       <= '0;
      dst_q       <= '0;
    end else begin
      rf_q        <= rf_d;
      halted_q    <= halted_d;
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      imm_q       <= imm_d;
      dst_q       <= dst_d;
    end
  end

  assign halted    = halted_q;
  assign out_valid = out_valid_q;
  assign out_ctrl  = ctrl_q;
  assign out_src1  = src1_q;
  assign out_src2  = src2_q;
  assign out_imm   = imm_q;
  assign out_dst   = dst_q;
endmodule

// File: tb/tb_mod_id_pipe.sv
// Bench for mod_id_pipe: directed vectors, a cycle-level reference model compared every
// cycle, and hand-computed literal expectations.
module tb_mod_id_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_instr, in_pc;
  logic [2:0]  flags;
  logic        ex_valid, ex_memread;
  logic [3:0]  ex_dst;
  logic        wb_we;
  logic [3:0]  wb_dst;
  logic [15:0] wb_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted, out_valid, out_ready;
  logic [11:0] out_ctrl;
  logic [15:0] out_src1, out_src2, out_imm;
  logic [3:0]  out_dst;

  always #5 clk = ~clk;

  mod_id_pipe #(.DATA_W(16), .REG_AW(4), .IMM_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flags(flags), .ex_valid(ex_valid), .ex_memread(ex_memread),
    .ex_dst(ex_dst), .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_src1(out_src1), .out_src2(out_src2), .out_imm(out_imm), .out_dst(out_dst)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [11:0] ctrl;
    logic [15:0] src1, src2, imm;
    logic [3:0]  dst, s1i, s2i;
    bit          s1u, s2u, br, taken;
    logic [15:0] target;
  } dec_t;

  logic [15:0] m_rf [16];
  bit          m_valid, m_halted;
  dec_t        m_out;

  function automatic logic [15:0] m_read(input logic [3:0] idx);
    if (idx == 4'd0) return 16'h0;
`ifdef WB_BYPASS_EN
    if (wb_we && wb_dst == idx) return wb_data;
`endif
    return m_rf[idx];
  endfunction

  // flags = {Z,V,N}
  function automatic bit cond_holds(input logic [2:0] code, input logic [2:0] f);
    bit eq, lt, gt;
    eq = f[2]; lt = f[0]; gt = !eq && !lt;
    case (code)
      3'd0: return !eq;
      3'd1: return eq;
      3'd2: return gt;
      3'd3: return lt;
      3'd4: return gt || eq;
      3'd5: return lt || eq;
      3'd6: return f[1];
      default: return 1'b1;
    endcase
  endfunction

  function automatic dec_t m_decode(input logic [15:0] ins, input logic [15:0] pc,
                                    input logic [2:0] f);
    dec_t d;
    logic [3:0] op;
    logic signed [3:0] s4;
    logic signed [8:0] s9;
    bit rw, asrc, men, mwr, m2r, pcr;
    logic [1:0] brc;
    op = ins[15:12];
    s4 = ins[3:0];
    s9 = ins[8:0];
    d = '{default: '0};
    rw = 0; asrc = 0; men = 0; mwr = 0; m2r = 0; pcr = 0; brc = 2'b00;
    d.dst = ins[11:8];
    d.s1i = (op == 4'hA || op == 4'hB) ? ins[11:8] : ins[7:4];
    d.s2i = (op == 4'h9) ? ins[11:8] : ins[3:0];
    if (op <= 4'h7) begin
      rw = 1; d.s1u = 1;
      if (op >= 4'h4 && op <= 4'h6) begin
        asrc = 1; d.imm = 16'(ins[3:0]);
      end else begin
        d.s2u = 1; d.imm = 16'(int'(s4));
      end
    end else begin
      case (op)
        4'h8: begin rw = 1; asrc = 1; men = 1; m2r = 1; d.s1u = 1; d.imm = 16'(int'(s4) * 2); end
        4'h9: begin asrc = 1; men = 1; mwr = 1; d.s1u = 1; d.s2u = 1; d.imm = 16'(int'(s4) * 2); end
        4'hA, 4'hB: begin rw = 1; asrc = 1; d.s1u = 1; d.imm = 16'(ins[7:0]); end
        4'hC: begin brc = 2'b01; d.br = 1; d.imm = 16'(int'(s9) * 2); end
        4'hD: begin brc = 2'b10; d.br = 1; d.s1u = 1; end
        4'hE: begin rw = 1; pcr = 1; end
        default: ;
      endcase
    end
    d.ctrl  = {rw, asrc, men, mwr, m2r, pcr, op, brc};
    d.src1  = (op == 4'hE) ? pc : m_read(d.s1i);
    d.src2  = m_read(d.s2i);
    d.taken = d.br && cond_holds(ins[11:9], f);
    d.target = (op == 4'hD) ? m_read(d.s1i) : 16'(pc + d.imm);
    return d;
  endfunction

  function automatic void m_eval(output dec_t d, output bit ready, output bit acc);
    bit stall;
    d = m_decode(in_instr, in_pc, flags);
    stall = in_valid && ex_valid && ex_memread && ex_dst != 4'd0 &&
            ((d.s1u && ex_dst == d.s1i) || (d.s2u && ex_dst == d.s2i));
    ready = !m_halted && !stall && (!m_valid || out_ready);
    acc   = in_valid && ready;
  endfunction

  always @(posedge clk) begin
    dec_t d;
    bit   ready, acc;
    if (rst) begin
      m_valid  <= 0;
      m_halted <= 0;
      m_out    <= '{default: '0};
      for (int i = 0; i < 16; i++) m_rf[i] <= 16'h0;
    end else begin
      m_eval(d, ready, acc);
      if (acc) begin
        m_out   <= d;
        m_valid <= 1;
        if (in_instr[15:12] == 4'hF) m_halted <= 1;
      end else if (!m_valid || out_ready) begin
        m_valid <= 0;
      end
      if (wb_we && wb_dst != 4'd0) m_rf[wb_dst] <= wb_data;
    end
  end

  always @(negedge clk) begin
    dec_t d;
    bit   ready, acc;
    if (rst === 1'b0) begin
      m_eval(d, ready, acc);
      chk("m_in_ready", 32'(in_ready), 32'(ready));
      chk("m_redirect", 32'(redirect), 32'(acc && d.taken));
      if (acc && d.taken) chk("m_redirect_pc", 32'(redirect_pc), 32'(d.target));
      chk("m_out_valid", 32'(out_valid), 32'(m_valid));
      chk("m_halted", 32'(halted), 32'(m_halted));
      if (m_valid) begin
        chk("m_ctrl", 32'(out_ctrl), 32'(m_out.ctrl));
        chk("m_src1", 32'(out_src1), 32'(m_out.src1));
        chk("m_src2", 32'(out_src2), 32'(m_out.src2));
        chk("m_imm", 32'(out_imm), 32'(m_out.imm));
        chk("m_dst", 32'(out_dst), 32'(m_out.dst));
      end
    end
  end

  // ---------------- driver ----------------
  typedef struct {
    logic [15:0] ins, pc;
    logic [2:0]  f;
    bit          exv;
    logic [3:0]  exd;
    bit          ordy;
  } vec_t;

  vec_t vecs[20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{16'h8913, 16'h0020, 3'b000, 1'b0, 4'd0, 1'b1};
    vecs[1]  = '{16'h9215, 16'h0022, 3'b000, 1'b0, 4'd0, 1'b1};
    vecs[2]  = '{16'hA4A5, 16'h0024, 3'b000, 1'b0, 4'd0, 1'b1};
    vecs[3]  = '{16'hB45A, 16'h0026, 3'b000, 1'b0, 4'd0, 1'b0};
    vecs[4]  = '{16'h451F, 16'h0028, 3'b000, 1'b0, 4'd0, 1'b1};
    vecs[5]  = '{16'h651C, 16'h002A, 3'b000, 1'b0, 4'd0, 1'b1};
    vecs[6]  = '{16'h5312, 16'h002C, 3'b000, 1'b0, 4'd0, 1'b1};
    vecs[7]  = '{16'h731F, 16'h002E, 3'b000, 1'b0, 4'd0, 1'b1};
    vecs[8]  = '{16'hE600, 16'h1234, 3'b000, 1'b0, 4'd0, 1'b1};
    vecs[9]  = '{16'hDE10, 16'h0030, 3'b000, 1'b0, 4'd0, 1'b1};
    vecs[10] = '{16'hC600, 16'h0040, 3'b001, 1'b0, 4'd0, 1'b1};
    vecs[11] = '{16'hCC02, 16'h0042, 3'b000, 1'b0, 4'd0, 1'b1};
    vecs[12] = '{16'hCA02, 16'h0044, 3'b000, 1'b0, 4'd0, 1'b1};
    vecs[13] = '{16'hC802, 16'h0046, 3'b001, 1'b0, 4'd0, 1'b1};
    vecs[14] = '{16'hC002, 16'h0048, 3'b100, 1'b0, 4'd0, 1'b1};
    vecs[15] = '{16'h0312, 16'h004A, 3'b000, 1'b1, 4'd2, 1'b1};
    vecs[16] = '{16'h4312, 16'h004C, 3'b000, 1'b1, 4'd2, 1'b1};
    vecs[17] = '{16'h0300, 16'h004E, 3'b000, 1'b1, 4'd0, 1'b1};
    vecs[18] = '{16'hDE40, 16'h0050, 3'b000, 1'b1, 4'd4, 1'b1};
    vecs[19] = '{16'h3312, 16'h0052, 3'b010, 1'b0, 4'd0, 1'b1};

    rst = 1; in_valid = 0; in_instr = 16'h0; in_pc = 16'h0; flags = 3'b000;
    ex_valid = 0; ex_memread = 0; ex_dst = 4'd0;
    wb_we = 0; wb_dst = 4'd0; wb_data = 16'h0; out_ready = 1;
    tick(); tick();
    at_neg();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_ctrl", 32'(out_ctrl), 32'd0);
    chk("rst_src1", 32'(out_src1), 32'd0);
    chk("rst_dst", 32'(out_dst), 32'd0);

    // ADD r3,r1,r2 after writing r1=5, r2=7
    tick(); rst = 0; wb_we = 1; wb_dst = 4'd1; wb_data = 16'd5;
    tick(); wb_dst = 4'd2; wb_data = 16'd7;
    tick(); wb_we = 0; in_valid = 1; in_instr = 16'h0312; in_pc = 16'h0002;
    tick(); in_valid = 0;
    at_neg();
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_src1", 32'(out_src1), 32'd5);
    chk("add_src2", 32'(out_src2), 32'd7);
    chk("add_dst", 32'(out_dst), 32'd3);

    // load-use stall on SUB r5,r4,r1
    tick(); ex_valid = 1; ex_memread = 1; ex_dst = 4'd4;
    in_valid = 1; in_instr = 16'h1541; in_pc = 16'h0004;
    at_neg();
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_redirect", 32'(redirect), 32'd0);
    tick(); ex_valid = 0; ex_memread = 0;
    at_neg();
    chk("bubble_valid", 32'(out_valid), 32'd0);
    chk("unstall_ready", 32'(in_ready), 32'd1);
    tick(); in_valid = 0;
    at_neg();
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_dst", 32'(out_dst), 32'd5);
    chk("sub_src2", 32'(out_src2), 32'd5);

    // B EQ +4 words
    tick(); in_valid = 1; in_instr = 16'hC204; in_pc = 16'h0010; flags = 3'b100;
    at_neg();
    chk("beq_taken", 32'(redirect), 32'd1);
    chk("beq_target", 32'(redirect_pc), 32'h0018);
    tick(); flags = 3'b000;
    at_neg();
    chk("beq_not_taken", 32'(redirect), 32'd0);
    chk("branch_regwrite", 32'(out_ctrl[11]), 32'd0);

    // back-pressure
    tick(); in_instr = 16'h0712;
    tick(); in_instr = 16'h2812; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_dst", 32'(out_dst), 32'd7);
      chk("bp_src1", 32'(out_src1), 32'd5);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1;
    at_neg();
    chk("bp_release", 32'(in_ready), 32'd1);
    tick(); in_valid = 0;
    at_neg();
    chk("bp_next_dst", 32'(out_dst), 32'd8);

    // same-cycle write-back, then r0 write
    tick(); wb_we = 1; wb_dst = 4'd6; wb_data = 16'hBEEF; in_valid = 1; in_instr = 16'h0160;
    tick(); wb_dst = 4'd0; wb_data = 16'h1234; in_valid = 0;
    at_neg();
`ifdef WB_BYPASS_EN
    chk("wb_same_cycle", 32'(out_src1), 32'hBEEF);
`else
    chk("wb_same_cycle", 32'(out_src1), 32'h0000);
`endif
    tick(); wb_we = 0; in_valid = 1; in_instr = 16'h0206;
    tick(); in_valid = 0;
    at_neg();
    chk("r0_reads_zero", 32'(out_src1), 32'h0000);
    chk("r6_written", 32'(out_src2), 32'hBEEF);

    // model pins
    tick(); in_valid = 1; in_instr = 16'hC5FD; in_pc = 16'h0100; flags = 3'b000;
    at_neg();
    chk("bgt_back_target", 32'(redirect_pc), 32'h00FA);
    tick(); in_instr = 16'h891F;
    tick(); in_instr = 16'hE600; in_pc = 16'h1234;
    at_neg();
    chk("lw_neg_imm", 32'(out_imm), 32'hFFFE);
    tick(); in_valid = 0;
    at_neg();
    chk("pcs_src1", 32'(out_src1), 32'h1234);

    // directed table, checked by the model
    foreach (vecs[k]) begin
      tick();
      in_valid = 1; in_instr = vecs[k].ins; in_pc = vecs[k].pc; flags = vecs[k].f;
      ex_valid = vecs[k].exv; ex_memread = vecs[k].exv; ex_dst = vecs[k].exd;
      out_ready = vecs[k].ordy;
      tick();
      in_valid = 0; ex_valid = 0; ex_memread = 0; out_ready = 1;
    end

    // HLT
    tick(); in_valid = 1; in_instr = 16'hF000; in_pc = 16'h0060;
    tick(); in_instr = 16'h0312;
    at_neg();
    chk("hlt_halted", 32'(halted), 32'd1);
    chk("hlt_valid", 32'(out_valid), 32'd1);
    chk("hlt_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      at_neg();
      chk("halted_in_ready", 32'(in_ready), 32'd0);
    end
    tick(); rst = 1;
    tick(); rst = 0; in_valid = 0;
    at_neg();
    chk("rst2_halted", 32'(halted), 32'd0);
    chk("rst2_valid", 32'(out_valid), 32'd0);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
